// File: rtl/gmii_tx_framer.sv
`default_nettype none
// ============================================================================
//  Module      : gmii_tx_framer
//  Description : Drains 134-bit frame words from a show-ahead FIFO and
//                serialises them onto GMII TX with preamble, SFD and IFG.
//  Revision    : 1.0 - initial release
// ============================================================================
module gmii_tx_framer #(
    parameter int PREAMBLE_BYTES = 7,
    parameter int IFG_BYTES      = 12
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic [133:0] iv_fifo_rdata,
    input  logic         i_fifo_empty,
    output logic         o_fifo_rd,
    output logic [7:0]   ov_gmii_txd,
    output logic         o_gmii_tx_en,
    output logic         o_gmii_tx_er,
    output logic         o_underflow_pulse,
    output logic         o_format_err_pulse,
    output logic [15:0]  ov_tx_frame_cnt
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_PRE     = 3'd1,
        ST_SFD     = 3'd2,
        ST_DATA    = 3'd3,
        ST_IFG     = 3'd4,
        ST_DISCARD = 3'd5
    } state_t;

    localparam logic [1:0] C_TYPE_HEAD = 2'b01;
    localparam logic [1:0] C_TYPE_TAIL = 2'b10;
    localparam logic [1:0] C_TYPE_RSVD = 2'b11;
    localparam logic [7:0] C_PRE_LAST  = 8'(PREAMBLE_BYTES - 1);
    localparam logic [7:0] C_IFG_LAST  = 8'(IFG_BYTES - 1);
    localparam logic [7:0] C_PRE_BYTE  = 8'h55;
    localparam logic [7:0] C_SFD_BYTE  = 8'hD5;

    state_t        state_q, state_d;
    logic [3:0]    idx_q, idx_d;
    logic [7:0]    cnt_q, cnt_d;
    logic          first_q, first_d;
    logic [7:0]    txd_q, txd_d;
    logic          tx_en_q, tx_en_d;
    logic          tx_er_q, tx_er_d;
    logic          unf_q, unf_d;
    logic          fmt_q, fmt_d;
    logic [15:0]   frame_cnt_q, frame_cnt_d;

    logic          w_rd;
    logic [1:0]    w_type;
    logic [3:0]    w_inv;
    logic [127:0]  w_shifted;
    logic [7:0]    w_byte;
    logic [3:0]    w_last_idx;
    logic          w_is_last;
    logic          w_bad_follow;

    assign w_type       = iv_fifo_rdata[133:132];
    assign w_inv        = iv_fifo_rdata[131:128];
    assign w_shifted    = iv_fifo_rdata[127:0] << {idx_q, 3'b000};
    assign w_byte       = w_shifted[127:120];
    assign w_last_idx   = (w_type == C_TYPE_TAIL) ? (4'd15 - w_inv) : 4'd15;
    assign w_is_last    = (idx_q == w_last_idx);
    // A follow-on word must be present and be a middle or tail word.
    assign w_bad_follow = i_fifo_empty || (w_type == C_TYPE_HEAD) || (w_type == C_TYPE_RSVD);

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        cnt_d       = cnt_q;
        first_d     = first_q;
        txd_d       = 8'h00;
        tx_en_d     = 1'b0;
        tx_er_d     = 1'b0;
        unf_d       = 1'b0;
        fmt_d       = 1'b0;
        frame_cnt_d = frame_cnt_q;
        w_rd        = 1'b0;

        case (state_q)
            ST_IDLE: begin
                cnt_d = 8'd0;
                idx_d = 4'd0;
                if (!i_fifo_empty) begin
                    if (w_type == C_TYPE_HEAD) begin
                        state_d = ST_PRE;
                        first_d = 1'b1;
                    end else begin
                        w_rd  = 1'b1;
                        fmt_d = 1'b1;
                    end
                end
            end

            ST_PRE: begin
                txd_d   = C_PRE_BYTE;
                tx_en_d = 1'b1;
                if (cnt_q == C_PRE_LAST) begin
                    cnt_d   = 8'd0;
                    state_d = ST_SFD;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end

            ST_SFD: begin
                txd_d   = C_SFD_BYTE;
                tx_en_d = 1'b1;
                idx_d   = 4'd0;
                state_d = ST_DATA;
            end

            ST_DATA: begin
                tx_en_d = 1'b1;
                if (!first_q && (idx_q == 4'd0) && w_bad_follow) begin
                    tx_er_d = 1'b1;
                    unf_d   = 1'b1;
                    state_d = ST_DISCARD;
                end else begin
                    txd_d = w_byte;
                    if (w_is_last) begin
                        w_rd    = 1'b1;
                        first_d = 1'b0;
                        idx_d   = 4'd0;
                        if (w_type == C_TYPE_TAIL) begin
                            state_d     = ST_IFG;
                            cnt_d       = 8'd0;
                            frame_cnt_d = frame_cnt_q + 16'd1;
                        end
                    end else begin
                        idx_d = idx_q + 4'd1;
                    end
                end
            end

            ST_IFG: begin
                // The final gap cycle doubles as the IDLE decision so that a
                // waiting head word leaves exactly IFG_BYTES idle cycles.
                if (cnt_q == C_IFG_LAST) begin
                    cnt_d = 8'd0;
                    idx_d = 4'd0;
                    if (!i_fifo_empty && (w_type == C_TYPE_HEAD)) begin
                        state_d = ST_PRE;
                        first_d = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end

            ST_DISCARD: begin
                if (!i_fifo_empty) begin
                    w_rd = 1'b1;
                    if (w_type == C_TYPE_TAIL) begin
                        state_d = ST_IFG;
                        cnt_d   = 8'd0;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q     <= ST_IDLE;
            idx_q       <= 4'd0;
            cnt_q       <= 8'd0;
            first_q     <= 1'b0;
            txd_q       <= 8'h00;
            tx_en_q     <= 1'b0;
            tx_er_q     <= 1'b0;
            unf_q       <= 1'b0;
            fmt_q       <= 1'b0;
            frame_cnt_q <= 16'd0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            first_q     <= first_d;
            txd_q       <= txd_d;
            tx_en_q     <= tx_en_d;
            tx_er_q     <= tx_er_d;
            unf_q       <= unf_d;
            fmt_q       <= fmt_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    // Words must stay in the FIFO while reset is held.
    assign o_fifo_rd          = w_rd & i_rst_n;
    assign ov_gmii_txd        = txd_q;
    assign o_gmii_tx_en       = tx_en_q;
    assign o_gmii_tx_er       = tx_er_q;
    assign o_underflow_pulse  = unf_q;
    assign o_format_err_pulse = fmt_q;
    assign ov_tx_frame_cnt    = frame_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_gmii_tx_framer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_gmii_tx_framer
//  Description : Directed self-checking bench for gmii_tx_framer.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_gmii_tx_framer;

    localparam int PRE = 7;

    logic         clk   = 1'b0;
    logic         rst_n = 1'b0;
    logic [133:0] fifo_rdata;
    logic         fifo_empty;
    logic         fifo_rd;
    logic [7:0]   txd;
    logic         tx_en, tx_er, unf_p, fmt_p;
    logic [15:0]  frame_cnt;

    logic [133:0] mem [0:255];
    int wp = 0;
    int rp = 0;

    int tests = 0;
    int fails = 0;

    logic [7:0] cap [0:4095];
    int cap_n   = 0;
    int runs [0:63];
    int run_n   = 0;
    int gaps [0:63];
    int gap_n   = 0;
    int hi_run  = 0;
    int low_run = 0;
    logic prev_en = 1'b0;
    int er_cnt  = 0;
    int unf_cnt = 0;
    int fmt_cnt = 0;
    int rd_cnt  = 0;

    gmii_tx_framer #(.PREAMBLE_BYTES(7), .IFG_BYTES(12)) dut (
        .i_clk              (clk),
        .i_rst_n            (rst_n),
        .iv_fifo_rdata      (fifo_rdata),
        .i_fifo_empty       (fifo_empty),
        .o_fifo_rd          (fifo_rd),
        .ov_gmii_txd        (txd),
        .o_gmii_tx_en       (tx_en),
        .o_gmii_tx_er       (tx_er),
        .o_underflow_pulse  (unf_p),
        .o_format_err_pulse (fmt_p),
        .ov_tx_frame_cnt    (frame_cnt)
    );

    always #5 clk = ~clk;

    assign fifo_rdata = mem[rp[7:0]];
    assign fifo_empty = (rp == wp);

    always @(posedge clk) begin
        if (fifo_rd && !fifo_empty) begin
            rp     <= rp + 1;
            rd_cnt <= rd_cnt + 1;
        end
    end

    always @(negedge clk) begin
        prev_en <= tx_en;
        er_cnt  <= er_cnt + int'(tx_er);
        unf_cnt <= unf_cnt + int'(unf_p);
        fmt_cnt <= fmt_cnt + int'(fmt_p);
        if (tx_en) begin
            if (cap_n < 4096) cap[cap_n] <= txd;
            cap_n <= cap_n + 1;
            if (!prev_en) begin
                if (gap_n < 64) gaps[gap_n] <= low_run;
                gap_n  <= gap_n + 1;
                hi_run <= 1;
            end else begin
                hi_run <= hi_run + 1;
            end
            low_run <= 0;
        end else begin
            if (prev_en) begin
                if (run_n < 64) runs[run_n] <= hi_run;
                run_n   <= run_n + 1;
                low_run <= 1;
            end else begin
                low_run <= low_run + 1;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [7:0] pat(input int seed, input int i);
        return 8'((i * 7 + seed * 31 + 1) & 255);
    endfunction

    function automatic logic [127:0] mkdata(input int seed, input int w);
        logic [127:0] d;
        d = '0;
        for (int k = 0; k < 16; k++) d[127 - 8*k -: 8] = pat(seed, 16*w + k);
        return d;
    endfunction

    // Mismatching wire bytes (preamble, SFD, payload) starting at cap[start].
    function automatic int count_bad(input int start, input int len, input int seed);
        int bad;
        bad = 0;
        for (int i = 0; i < PRE; i++) if (cap[start + i] !== 8'h55) bad++;
        if (cap[start + PRE] !== 8'hD5) bad++;
        for (int i = 0; i < len; i++) if (cap[start + PRE + 1 + i] !== pat(seed, i)) bad++;
        return bad;
    endfunction

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic push_word(input logic [1:0] t, input logic [3:0] inv, input logic [127:0] d);
        mem[wp[7:0]] = {t, inv, d};
        wp = wp + 1;
    endtask

    task automatic push_frame(input int len, input int seed);
        int nw;
        nw = (len + 15) / 16;
        for (int w = 0; w < nw; w++) begin
            if (w == 0)           push_word(2'b01, 4'd0, mkdata(seed, w));
            else if (w == nw - 1) push_word(2'b10, 4'(nw*16 - len), mkdata(seed, w));
            else                  push_word(2'b00, 4'd0, mkdata(seed, w));
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) step();
        tests++; if (txd !== 8'h00)      begin fails++; $display("FAIL reset_txd: got %h want 00", txd); end
        tests++; if (tx_en !== 1'b0)     begin fails++; $display("FAIL reset_tx_en: got %b want 0", tx_en); end
        tests++; if (tx_er !== 1'b0)     begin fails++; $display("FAIL reset_tx_er: got %b want 0", tx_er); end
        tests++; if (fifo_rd !== 1'b0)   begin fails++; $display("FAIL reset_fifo_rd: got %b want 0", fifo_rd); end
        tests++; if ({unf_p, fmt_p} !== 2'b00) begin fails++; $display("FAIL reset_pulses: got %b want 00", {unf_p, fmt_p}); end
        tests++; if (frame_cnt !== 16'd0) begin fails++; $display("FAIL reset_cnt: got %0d want 0", frame_cnt); end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_single_frame();
        int s_run, s_cap, s_rd, s_er, bad;
        s_run = run_n; s_cap = cap_n; s_rd = rd_cnt; s_er = er_cnt;
        push_frame(60, 1);
        step();
        tests++; if (tx_en !== 1'b0) begin fails++; $display("FAIL latency_early: tx_en got %b want 0", tx_en); end
        step();
        tests++; if ({tx_en, txd} !== {1'b1, 8'h55}) begin fails++; $display("FAIL latency_first: got en=%b txd=%h want en=1 txd=55", tx_en, txd); end
        repeat (90) step();
        tests++; if (run_n !== s_run + 1) begin fails++; $display("FAIL f60_runs: got %0d want %0d", run_n - s_run, 1); end
        tests++; if (runs[s_run] !== 68) begin fails++; $display("FAIL f60_len: got %0d want 68", runs[s_run]); end
        bad = count_bad(s_cap, 60, 1);
        tests++; if (bad !== 0) begin fails++; $display("FAIL f60_bytes: got %0d bad bytes want 0", bad); end
        tests++; if (rd_cnt - s_rd !== 4) begin fails++; $display("FAIL f60_pops: got %0d want 4", rd_cnt - s_rd); end
        tests++; if (er_cnt !== s_er) begin fails++; $display("FAIL f60_tx_er: got %0d want 0", er_cnt - s_er); end
        tests++; if (frame_cnt !== 16'd1) begin fails++; $display("FAIL f60_cnt: got %0d want 1", frame_cnt); end
    endtask

    task automatic test_back_to_back();
        int s_run, s_cap, s_gap, bad;
        s_run = run_n; s_cap = cap_n; s_gap = gap_n;
        push_frame(64, 2);
        push_frame(64, 3);
        repeat (200) step();
        tests++; if (runs[s_run] !== 72)     begin fails++; $display("FAIL b2b_len_a: got %0d want 72", runs[s_run]); end
        tests++; if (runs[s_run + 1] !== 72) begin fails++; $display("FAIL b2b_len_b: got %0d want 72", runs[s_run + 1]); end
        tests++; if (gaps[s_gap + 1] !== 12) begin fails++; $display("FAIL b2b_gap: got %0d want 12", gaps[s_gap + 1]); end
        bad = count_bad(s_cap, 64, 2) + count_bad(s_cap + 72, 64, 3);
        tests++; if (bad !== 0) begin fails++; $display("FAIL b2b_bytes: got %0d bad bytes want 0", bad); end
        tests++; if (frame_cnt !== 16'd3) begin fails++; $display("FAIL b2b_cnt: got %0d want 3", frame_cnt); end
    endtask

    task automatic test_underflow();
        int s_run, s_cap, s_rd, s_er, s_unf, s_fmt, cycles, bad;
        s_run = run_n; s_cap = cap_n; s_rd = rd_cnt; s_er = er_cnt; s_unf = unf_cnt;
        push_word(2'b01, 4'd0, mkdata(4, 0));
        push_word(2'b00, 4'd0, mkdata(4, 1));
        repeat (60) step();
        tests++; if (unf_cnt - s_unf !== 1) begin fails++; $display("FAIL unf_pulse: got %0d want 1", unf_cnt - s_unf); end
        tests++; if (er_cnt - s_er !== 1)   begin fails++; $display("FAIL unf_tx_er: got %0d want 1", er_cnt - s_er); end
        tests++; if (runs[s_run] !== 41)    begin fails++; $display("FAIL unf_len: got %0d want 41", runs[s_run]); end
        tests++; if (cap[s_cap + 40] !== 8'h00) begin fails++; $display("FAIL unf_byte: got %h want 00", cap[s_cap + 40]); end
        bad = count_bad(s_cap, 32, 4);
        tests++; if (bad !== 0) begin fails++; $display("FAIL unf_bytes: got %0d bad bytes want 0", bad); end
        tests++; if (frame_cnt !== 16'd3)   begin fails++; $display("FAIL unf_cnt: got %0d want 3", frame_cnt); end
        tests++; if (rd_cnt - s_rd !== 2)   begin fails++; $display("FAIL unf_pops: got %0d want 2", rd_cnt - s_rd); end

        s_rd = rd_cnt; s_fmt = fmt_cnt; s_cap = cap_n; s_unf = unf_cnt;
        push_word(2'b10, 4'd0, mkdata(4, 2));
        push_frame(32, 5);
        cycles = 0;
        while (cycles < 40) begin
            step();
            if (tx_en) break;
            cycles++;
        end
        tests++; if (cycles !== 13) begin fails++; $display("FAIL discard_ifg: tx_en rose after %0d cycles want 13", cycles); end
        repeat (50) step();
        tests++; if (rd_cnt - s_rd !== 3) begin fails++; $display("FAIL discard_pops: got %0d want 3", rd_cnt - s_rd); end
        tests++; if ((fmt_cnt - s_fmt) + (unf_cnt - s_unf) !== 0) begin fails++; $display("FAIL discard_silent: got %0d pulses want 0", (fmt_cnt - s_fmt) + (unf_cnt - s_unf)); end
        bad = count_bad(s_cap, 32, 5);
        tests++; if (bad !== 0) begin fails++; $display("FAIL after_unf_bytes: got %0d bad bytes want 0", bad); end
        tests++; if (frame_cnt !== 16'd4) begin fails++; $display("FAIL after_unf_cnt: got %0d want 4", frame_cnt); end
    endtask

    task automatic test_format_err();
        int s_run, s_cap, s_rd, s_fmt, bad;
        s_run = run_n; s_rd = rd_cnt; s_fmt = fmt_cnt;
        push_word(2'b00, 4'd0, mkdata(9, 0));
        repeat (5) step();
        tests++; if (fmt_cnt - s_fmt !== 1) begin fails++; $display("FAIL fmt_pulse: got %0d want 1", fmt_cnt - s_fmt); end
        tests++; if (rd_cnt - s_rd !== 1)   begin fails++; $display("FAIL fmt_pop: got %0d want 1", rd_cnt - s_rd); end
        tests++; if (run_n !== s_run)       begin fails++; $display("FAIL fmt_tx_en: got %0d runs want 0", run_n - s_run); end
        s_cap = cap_n;
        push_frame(48, 6);
        repeat (80) step();
        tests++; if (runs[s_run] !== 56) begin fails++; $display("FAIL fmt_next_len: got %0d want 56", runs[s_run]); end
        bad = count_bad(s_cap, 48, 6);
        tests++; if (bad !== 0) begin fails++; $display("FAIL fmt_next_bytes: got %0d bad bytes want 0", bad); end
        tests++; if (frame_cnt !== 16'd5) begin fails++; $display("FAIL fmt_next_cnt: got %0d want 5", frame_cnt); end
    endtask

    task automatic test_reset_mid_frame();
        int s_run, s_er, s_fmt, hi, cycles;
        s_run = run_n; s_er = er_cnt;
        push_frame(64, 7);
        hi = 0; cycles = 0;
        while (hi < 28 && cycles < 100) begin
            step();
            if (tx_en) hi++;
            cycles++;
        end
        tests++; if (txd !== pat(7, 19)) begin fails++; $display("FAIL rst_byte20: got %h want %h", txd, pat(7, 19)); end
        rst_n = 1'b0;
        step();
        tests++; if ({tx_en, tx_er} !== 2'b00) begin fails++; $display("FAIL rst_mid_en: got en=%b er=%b want 0 0", tx_en, tx_er); end
        tests++; if (txd !== 8'h00)        begin fails++; $display("FAIL rst_mid_txd: got %h want 00", txd); end
        tests++; if ({unf_p, fmt_p, fifo_rd} !== 3'b000) begin fails++; $display("FAIL rst_mid_strobes: got %b want 000", {unf_p, fmt_p, fifo_rd}); end
        tests++; if (frame_cnt !== 16'd0)  begin fails++; $display("FAIL rst_mid_cnt: got %0d want 0", frame_cnt); end
        step();
        tests++; if (runs[s_run] !== 28)   begin fails++; $display("FAIL rst_mid_len: got %0d want 28", runs[s_run]); end
        s_fmt = fmt_cnt;
        step();
        rst_n = 1'b1;
        repeat (10) step();
        tests++; if (fmt_cnt - s_fmt !== 3) begin fails++; $display("FAIL rst_leftover: got %0d format pulses want 3", fmt_cnt - s_fmt); end
        tests++; if (fifo_empty !== 1'b1)   begin fails++; $display("FAIL rst_drain: fifo empty got %b want 1", fifo_empty); end
        tests++; if (run_n !== s_run + 1 || er_cnt !== s_er) begin fails++; $display("FAIL rst_quiet: got %0d runs %0d er want 1 0", run_n - s_run, er_cnt - s_er); end
    endtask

    task automatic test_wrap();
        int s_run, s_cap, s_rd, bad;
        force dut.frame_cnt_q = 16'hFFFF;
        step();
        step();
        release dut.frame_cnt_q;
        s_run = run_n; s_cap = cap_n; s_rd = rd_cnt;
        push_frame(17, 8);
        repeat (50) step();
        tests++; if (frame_cnt !== 16'h0000) begin fails++; $display("FAIL wrap_cnt: got %h want 0000", frame_cnt); end
        tests++; if (runs[s_run] !== 25)     begin fails++; $display("FAIL inv15_len: got %0d want 25", runs[s_run]); end
        bad = count_bad(s_cap, 17, 8);
        tests++; if (bad !== 0)              begin fails++; $display("FAIL inv15_bytes: got %0d bad bytes want 0", bad); end
        tests++; if (rd_cnt - s_rd !== 2)    begin fails++; $display("FAIL inv15_pops: got %0d want 2", rd_cnt - s_rd); end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_underflow();
        test_format_err();
        test_reset_mid_frame();
        test_wrap();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
